spram_lsu32: RTL and testbench
==============================

// Module: spram_lsu32
// PURPOSE
//  Byte-addressed load/store unit sitting directly upstream of the 32K x 32 SPRAM (iBus32 master side).
//  Turns byte/half/word requests at any alignment into one or two word-bus cycles with lane masks.
//  Merges and extends read data, and returns it with a valid strobe.
//  Serves the Forth core's byte-addressed dictionary and stack accesses.
// PARAMETERS
//  AW  17  byte-address width; word address = ai[AW-1:2]; AW<=17, unused bus.ai MSBs driven 0
// PORTS
//  clk     in   1   system clock, all state on posedge
//  rst_n   in   1   asynchronous active-low reset
//  req     in   1   request valid; accepted on the posedge where req & rdy
//  rdy     out  1   unit idle, can accept a request (1 only in IDLE)
//  we      in   1   1=store, 0=load
//  sz      in   2   00 byte, 01 half, 10 word, 11 treated as word
//  sgn     in   1   load: 1 sign-extend, 0 zero-extend (ignored for word)
//  ai      in   AW  byte address, any alignment
//  vi      in   32  store data, right-justified
//  vo      out  32  load data, right-justified and extended
//  vo_vld  out  1   one-cycle strobe: vo valid
//  bus     iBus32.master  we/bmsk/ai/vi driven, vo sampled (SPRAM read data valid 1 cycle after ai)
// BEHAVIOUR
//  Reset: state=IDLE; rdy=1 once rst_n deasserts; vo_vld=0, vo=0; bus.we=0, bmsk=0, ai=0, vi=0
//  All request fields are latched on acceptance; inputs are ignored while rdy=0.
//  Lane k = bits[8k+7:8k], bmsk[k]; bmsk[k]=1 means lane k is written. Little-endian.
//  o=ai[1:0]; n=1/2/4 bytes; split = (o+n>4) -> second word wa+1 (0x7FFF wraps to 0x0000).
//  Store: w64=(vi & szmask)<<8o; m8=szlanes<<o. Word wa gets {w64[31:0],m8[3:0]}, word wa+1 gets {w64[63:32],m8[7:4]}.
//  Load: r64={hi,lo}>>8o, truncated to n bytes, then sign/zero-extended per sgn.
//  FSM:
//   IDLE   rdy=1; req -> ISSUE0
//   ISSUE0 bus.ai=wa, bmsk=lo lanes, we=lat_we
//          next: split ? ISSUE1 : (load ? RESP : IDLE)
//   ISSUE1 bus.ai=wa+1, bmsk=hi lanes, we=lat_we; load: capture bus.vo as lo
//          next: load ? RESP : IDLE
//   RESP   bus.we=0, bmsk=0; vo_vld=1; vo from bus.vo (hi, or only word) merged with captured lo
//          next: IDLE
//  Bus outputs are registered, so bus.we is 0 and bmsk is 0000 outside ISSUE states; bus.ai holds its last value.
//  Load bmsk: a load drives the lanes it reads, but bus.we=0, so no lanes are written.
//  Latency (accept at T):
//   aligned store  bus.we at T+1; rdy at T+2
//   aligned load   vo_vld at T+2; rdy at T+3
//   split store    rdy at T+3
//   split load     vo_vld at T+3; rdy at T+4
//  vo holds its value after vo_vld drops; vo changes only in RESP.
//  Reset mid-operation: abort immediately; bus.we=0 asynchronously; no vo_vld.
//   A half-finished split store leaves word wa written; there is no rollback.
//  A req held high during busy is not double-accepted; it is taken on the next IDLE cycle.
// STRUCTURE
//  Package spram_pkg:
//   iBus32 gains modport master(output we,bmsk,ai,vi; input vo)
//   typedef enum logic[1:0] {SZ_B,SZ_H,SZ_W} sz_t
//   typedef enum {IDLE,ISSUE0,ISSUE1,RESP} lsu_st_t
//  Sub-module lsu_align (combinational): store shift/mask generation, load merge/shift/extend.
//  Top holds the FSM, request latch, lo-word capture, and bus registers.
// TESTING
//  1 st word 0xDEADBEEF @0x00100 -> T+1 bus.ai=0x0040 bmsk=1111 we=1; ld word @0x00100 -> vo_vld T+2, vo=0xDEADBEEF
//  2 st byte 0xA5 @0x00103 -> bmsk=1000, bus.vi[31:24]=0xA5; ld byte sgn=1 -> 0xFFFFFFA5; sgn=0 -> 0x000000A5
//  3 st word 0x11223344 @0x00202 -> ai 0x0080 bmsk=1100 vi[31:16]=0x3344, then ai 0x0081 bmsk=0011 vi[15:0]=0x1122;
//    ld word @0x00202 -> vo_vld T+3, vo=0x11223344
//  4 st half 0x8001 @0x00007 -> ai 0x0001 bmsk=1000, ai 0x0002 bmsk=0001; ld half sgn=1 -> 0xFFFF8001
//  5 st word @0x1FFFE -> ai 0x7FFF bmsk=1100, then ai 0x0000 bmsk=0011 (wrap)
//  6 rst_n low during ISSUE1 of case 3 -> bus.we=0 at once, no vo_vld, rdy=1 after release;
//    req held high through a load -> exactly one bus transaction per request

Source files
------------

// File: rtl/spram_lsu32_pkg.sv
// Shared types and helpers for the byte-addressed SPRAM load/store unit.
// Latency: none (declarations only).
// Backpressure: none.
package spram_lsu32_pkg;

    // Word-address width of the 32K x 32 SPRAM bus.
    localparam int BUS_AW = 15;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } sz_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE0 = 2'd1,
        ISSUE1 = 2'd2,
        RESP   = 2'd3
    } lsu_st_t;

    // Access size in bytes; the unused 2'b11 encoding behaves as a word.
    function automatic logic [2:0] sz_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    sz_bytes = 3'd1;
            SZ_H:    sz_bytes = 3'd2;
            default: sz_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/spram_lsu32_if.sv
// Word bus between the load/store unit (master) and the SPRAM (slave).
// Latency: read data on vo is valid one cycle after ai is presented.
// Backpressure: none; the SPRAM accepts a cycle every clock.
interface spram_lsu32_if;
    import spram_lsu32_pkg::*;

    logic              we;
    logic [3:0]        bmsk;
    logic [BUS_AW-1:0] ai;
    logic [31:0]       vi;
    logic [31:0]       vo;

    modport master (output we, bmsk, ai, vi, input vo);
    modport slave  (input we, bmsk, ai, vi, output vo);
endinterface

// File: rtl/spram_lsu32_align.sv
// Lane alignment: store shift/mask generation and load merge/shift/extend.
// Latency: purely combinational.
// Backpressure: none.
module spram_lsu32_align
    import spram_lsu32_pkg::*;
(
    input  logic [1:0]  i_sz,
    input  logic        i_sgn,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_vi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    output logic [63:0] o_w64,
    output logic [7:0]  o_m8,
    output logic        o_split,
    output logic [31:0] o_ld
);

    logic [2:0]  w_n;
    logic [31:0] w_szmask;
    logic [3:0]  w_lanes;
    logic [31:0] w_r32;

    assign w_n     = sz_bytes(i_sz);
    // Access crosses into the next word when offset plus size exceeds 4 bytes.
    assign o_split = (({1'b0, i_off} + w_n) > 3'd4);

    // Size-dependent data mask and lane pattern before shifting to the offset.
    always_comb begin
        w_szmask = 32'hFFFF_FFFF;
        w_lanes  = 4'b1111;
        case (i_sz)
            SZ_B: begin
                w_szmask = 32'h0000_00FF;
                w_lanes  = 4'b0001;
            end
            SZ_H: begin
                w_szmask = 32'h0000_FFFF;
                w_lanes  = 4'b0011;
            end
            default: ;
        endcase
    end

    assign o_w64 = {32'd0, i_vi & w_szmask} << {i_off, 3'b000};
    assign o_m8  = {4'd0, w_lanes} << i_off;

    // Only the low 32 bits of the shifted pair can hold the requested bytes.
    assign w_r32 = 32'({i_hi, i_lo} >> {i_off, 3'b000});

    // Truncate to the access size and extend; word loads ignore sgn.
    always_comb begin
        o_ld = w_r32;
        case (i_sz)
            SZ_B:    o_ld = {{24{i_sgn & w_r32[7]}}, w_r32[7:0]};
            SZ_H:    o_ld = {{16{i_sgn & w_r32[15]}}, w_r32[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/spram_lsu32.sv
// Byte-addressed load/store unit mastering the 32K x 32 SPRAM word bus.
// Latency: aligned store 1 bus cycle, aligned load 2, split store 2, split load 3.
// Backpressure: o_rdy is high only when idle; requests are taken on req & rdy.
module spram_lsu32
    import spram_lsu32_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    output logic          o_rdy,
    input  logic          i_we,
    input  logic [1:0]    i_sz,
    input  logic          i_sgn,
    input  logic [AW-1:0] i_ai,
    input  logic [31:0]   i_vi,
    output logic [31:0]   o_vo,
    output logic          o_vo_vld,
    spram_lsu32_if.master bus
);

    lsu_st_t           r_st;
    lsu_st_t           w_nxt;

    logic              r_we;
    logic [1:0]        r_sz;
    logic              r_sgn;
    logic [AW-1:0]     r_ai;
    logic [31:0]       r_vi;
    logic [31:0]       r_lo;
    logic [31:0]       r_vo;

    logic              r_bus_we;
    logic [3:0]        r_bus_bmsk;
    logic [BUS_AW-1:0] r_bus_ai;
    logic [31:0]       r_bus_vi;

    logic              w_idle;
    logic              w_acc;
    logic              w_sel_we;
    logic [1:0]        w_sel_sz;
    logic              w_sel_sgn;
    logic [AW-1:0]     w_sel_ai;
    logic [31:0]       w_sel_vi;
    logic [AW-3:0]     w_wa;
    logic [AW-3:0]     w_wa1;
    logic [63:0]       w_w64;
    logic [7:0]        w_m8;
    logic              w_split;
    logic [31:0]       w_lo_dat;
    logic [31:0]       w_ld;

    assign w_idle = (r_st == IDLE);
    assign w_acc  = i_req & w_idle;
    assign o_rdy  = w_idle;

    // While idle the live request fields feed the aligner so ISSUE0 can be
    // registered on the accepting edge; afterwards the latched copy is used.
    assign w_sel_we  = w_idle ? i_we  : r_we;
    assign w_sel_sz  = w_idle ? i_sz  : r_sz;
    assign w_sel_sgn = w_idle ? i_sgn : r_sgn;
    assign w_sel_ai  = w_idle ? i_ai  : r_ai;
    assign w_sel_vi  = w_idle ? i_vi  : r_vi;

    assign w_wa  = w_sel_ai[AW-1:2];
    assign w_wa1 = w_wa + 1'b1;

    // In RESP bus.vo carries the high word of a split load, or the only word.
    assign w_lo_dat = w_split ? r_lo : bus.vo;

    spram_lsu32_align u_align (
        .i_sz    (w_sel_sz),
        .i_sgn   (w_sel_sgn),
        .i_off   (w_sel_ai[1:0]),
        .i_vi    (w_sel_vi),
        .i_lo    (w_lo_dat),
        .i_hi    (bus.vo),
        .o_w64   (w_w64),
        .o_m8    (w_m8),
        .o_split (w_split),
        .o_ld    (w_ld)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= IDLE;
        else        r_st <= w_nxt;
    end

    // Next-state: optional second word, then a response cycle for loads.
    always_comb begin
        w_nxt = r_st;
        case (r_st)
            IDLE:    if (i_req) w_nxt = ISSUE0;
            ISSUE0:  w_nxt = w_split ? ISSUE1 : (r_we ? IDLE : RESP);
            ISSUE1:  w_nxt = r_we ? IDLE : RESP;
            RESP:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Latch every request field on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_sz  <= 2'd0;
            r_sgn <= 1'b0;
            r_ai  <= '0;
            r_vi  <= 32'd0;
        end else if (w_acc) begin
            r_we  <= i_we;
            r_sz  <= i_sz;
            r_sgn <= i_sgn;
            r_ai  <= i_ai;
            r_vi  <= i_vi;
        end
    end

    // Bus registers load the values of the state being entered; the address
    // and data hold outside the issue states while we/bmsk drop to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_we   <= 1'b0;
            r_bus_bmsk <= 4'd0;
            r_bus_ai   <= '0;
            r_bus_vi   <= 32'd0;
        end else begin
            case (w_nxt)
                ISSUE0: begin
                    r_bus_we   <= w_sel_we;
                    r_bus_bmsk <= w_m8[3:0];
                    r_bus_ai   <= BUS_AW'(w_wa);
                    r_bus_vi   <= w_w64[31:0];
                end
                ISSUE1: begin
                    r_bus_we   <= w_sel_we;
                    r_bus_bmsk <= w_m8[7:4];
                    r_bus_ai   <= BUS_AW'(w_wa1);
                    r_bus_vi   <= w_w64[63:32];
                end
                default: begin
                    r_bus_we   <= 1'b0;
                    r_bus_bmsk <= 4'd0;
                end
            endcase
        end
    end

    // Capture the low word of a split load, and hold the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo <= 32'd0;
            r_vo <= 32'd0;
        end else begin
            if (r_st == ISSUE1) r_lo <= bus.vo;
            if (r_st == RESP)   r_vo <= w_ld;
        end
    end

    assign bus.we   = r_bus_we;
    assign bus.bmsk = r_bus_bmsk;
    assign bus.ai   = r_bus_ai;
    assign bus.vi   = r_bus_vi;

    assign o_vo_vld = (r_st == RESP);
    assign o_vo     = (r_st == RESP) ? w_ld : r_vo;

endmodule

// File: tb/tb_spram_lsu32.sv
// Bench for spram_lsu32: SPRAM model, byte-level reference model, per-cycle compare.
// Latency: expected bus/response cycles are derived from the acceptance edge.
// Backpressure: requests wait on o_rdy with a bounded cycle budget.
module tb_spram_lsu32;
    import spram_lsu32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  sz = 2'd0;
    logic        sgn = 1'b0;
    logic [16:0] ai = 17'd0;
    logic [31:0] vi = 32'd0;
    logic [31:0] vo;
    logic        vo_vld;
    logic        rdy;

    always #5 clk = ~clk;

    spram_lsu32_if bus_if ();

    spram_lsu32 #(.AW(17)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req),
        .o_rdy    (rdy),
        .i_we     (we),
        .i_sz     (sz),
        .i_sgn    (sgn),
        .i_ai     (ai),
        .i_vi     (vi),
        .o_vo     (vo),
        .o_vo_vld (vo_vld),
        .bus      (bus_if)
    );

    // SPRAM: lane-masked write, registered read one cycle after the address.
    logic [31:0] mem [0:32767];
    always @(posedge clk) begin : spram
        logic [31:0] w;
        w = mem[bus_if.ai];
        if (bus_if.we) begin
            for (int k = 0; k < 4; k++)
                if (bus_if.bmsk[k]) w[8*k +: 8] = bus_if.vi[8*k +: 8];
            mem[bus_if.ai] <= w;
        end
        bus_if.vo <= mem[bus_if.ai];
    end

    // Reference model: flat byte memory plus expected bus and response queues.
    logic [7:0] bm [0:131071];
    typedef struct { logic [14:0] a; logic [3:0] m; logic w; logic [31:0] d; int c; } txn_t;
    typedef struct { logic [31:0] v; int c; } ld_t;
    txn_t tq[$];
    ld_t  lq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int free_cyc = 0;
    int n_acc = 0;
    int n_obs = 0;
    logic        rdy_neg = 1'b0;
    logic [31:0] last_vo = 32'd0;
    logic [14:0] obs_ai [0:1];
    logic [3:0]  obs_m  [0:1];
    logic [31:0] obs_vi [0:1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance monitor: apply each request to the byte model, derive bus words
    // byte by byte, and schedule expected bus cycles and the load response.
    always @(posedge clk) begin : monitor
        int n;
        logic [16:0] b;
        logic [14:0] wa;
        logic [3:0]  m0, m1;
        logic [31:0] d0, d1, val;
        cyc++;
        if (rst_n && req && rdy_neg) begin
            n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            wa = ai[16:2];
            m0 = 4'd0; m1 = 4'd0; d0 = 32'd0; d1 = 32'd0; val = 32'd0;
            for (int i = 0; i < n; i++) begin
                b = ai + 17'(i);
                if (b[16:2] == wa) begin
                    m0[b[1:0]] = 1'b1;
                    d0[8*b[1:0] +: 8] = vi[8*i +: 8];
                end else begin
                    m1[b[1:0]] = 1'b1;
                    d1[8*b[1:0] +: 8] = vi[8*i +: 8];
                end
                if (we) bm[b] = vi[8*i +: 8];
                else    val[8*i +: 8] = bm[b];
            end
            if (!we && sgn && n == 1) val = {{24{val[7]}}, val[7:0]};
            if (!we && sgn && n == 2) val = {{16{val[15]}}, val[15:0]};
            tq.push_back('{a: wa, m: m0, w: we, d: d0, c: cyc});
            if (m1 != 4'd0) tq.push_back('{a: wa + 15'd1, m: m1, w: we, d: d1, c: cyc + 1});
            if (!we) lq.push_back('{v: val, c: cyc + 1 + ((m1 != 4'd0) ? 1 : 0)});
            free_cyc = cyc + 1 + ((m1 != 4'd0) ? 1 : 0) + (we ? 0 : 1);
            n_acc++;
        end
    end

    // Per-cycle compare of rdy, bus and response against the model.
    always @(negedge clk) begin : compare
        txn_t t;
        ld_t  l;
        logic [31:0] msk;
        rdy_neg = rdy;
        if (!rst_n) begin
            tq.delete();
            lq.delete();
            last_vo  = 32'd0;
            free_cyc = 0;
        end else begin
            chk("rdy", {31'd0, rdy}, (cyc >= free_cyc) ? 32'd1 : 32'd0);
            while (tq.size() > 0 && tq[0].c < cyc) begin
                t = tq.pop_front();
                chk("bus_missed_cycle", 32'(cyc), 32'(t.c));
            end
            if (tq.size() > 0 && tq[0].c == cyc) begin
                t = tq.pop_front();
                msk = 32'd0;
                for (int k = 0; k < 4; k++) if (t.m[k]) msk[8*k +: 8] = 8'hFF;
                chk("bus_ai", 32'(bus_if.ai), 32'(t.a));
                chk("bus_bmsk", 32'(bus_if.bmsk), 32'(t.m));
                chk("bus_we", 32'(bus_if.we), 32'(t.w));
                if (t.w) chk("bus_vi", bus_if.vi & msk, t.d & msk);
                if (n_obs < 2) begin
                    obs_ai[n_obs] = bus_if.ai;
                    obs_m[n_obs]  = bus_if.bmsk;
                    obs_vi[n_obs] = bus_if.vi;
                end
                n_obs++;
            end else begin
                chk("bus_idle_we", 32'(bus_if.we), 32'd0);
                chk("bus_idle_bmsk", 32'(bus_if.bmsk), 32'd0);
            end
            if (lq.size() > 0 && lq[0].c == cyc) begin
                l = lq.pop_front();
                chk("vo_vld", 32'(vo_vld), 32'd1);
                chk("vo", vo, l.v);
                last_vo = l.v;
            end else begin
                chk("vo_vld_idle", 32'(vo_vld), 32'd0);
                chk("vo_hold", vo, last_vo);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!rdy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!rdy) chk("rdy_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic op(input logic w, input logic [1:0] s, input logic g,
                      input logic [16:0] a, input logic [31:0] v);
        @(negedge clk);
        wait_idle();
        #1;
        we = w; sz = s; sgn = g; ai = a; vi = v; req = 1'b1;
        n_obs = 0;
        @(negedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        wait_idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0;
        logic [7:0] s4, s5;
        for (int i = 0; i < 32768; i++) mem[i] = 32'd0;
        for (int i = 0; i < 131072; i++) bm[i] = 8'd0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_bus_we", 32'(bus_if.we), 32'd0);
        chk("rst_bus_bmsk", 32'(bus_if.bmsk), 32'd0);
        chk("rst_bus_ai", 32'(bus_if.ai), 32'd0);
        chk("rst_bus_vi", bus_if.vi, 32'd0);
        chk("rst_vo", vo, 32'd0);
        chk("rst_vo_vld", 32'(vo_vld), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(rdy), 32'd1);

        // Aligned word store and load.
        op(1'b1, 2'd2, 1'b0, 17'h00100, 32'hDEADBEEF);
        chk("c1_st_ai", 32'(obs_ai[0]), 32'h0040);
        chk("c1_st_bmsk", 32'(obs_m[0]), 32'hF);
        chk("c1_st_cnt", 32'(n_obs), 32'd1);
        op(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        chk("c1_ld", last_vo, 32'hDEADBEEF);

        // Byte store at lane 3, signed and unsigned byte loads.
        op(1'b1, 2'd0, 1'b0, 17'h00103, 32'h123456A5);
        chk("c2_st_bmsk", 32'(obs_m[0]), 32'h8);
        chk("c2_st_vi", {24'd0, obs_vi[0][31:24]}, 32'hA5);
        op(1'b0, 2'd0, 1'b1, 17'h00103, 32'd0);
        chk("c2_ld_s", last_vo, 32'hFFFFFFA5);
        op(1'b0, 2'd0, 1'b0, 17'h00103, 32'd0);
        chk("c2_ld_u", last_vo, 32'h000000A5);
        op(1'b0, 2'd3, 1'b1, 17'h00100, 32'd0);
        chk("sz11_ld", last_vo, 32'hA5ADBEEF);
        op(1'b0, 2'd1, 1'b1, 17'h00101, 32'd0);
        chk("half_off1_ld", last_vo, 32'hFFFFADBE);

        // Split word store and load.
        op(1'b1, 2'd2, 1'b0, 17'h00202, 32'h11223344);
        chk("c3_cnt", 32'(n_obs), 32'd2);
        chk("c3_ai0", 32'(obs_ai[0]), 32'h0080);
        chk("c3_m0", 32'(obs_m[0]), 32'hC);
        chk("c3_vi0", {16'd0, obs_vi[0][31:16]}, 32'h3344);
        chk("c3_ai1", 32'(obs_ai[1]), 32'h0081);
        chk("c3_m1", 32'(obs_m[1]), 32'h3);
        chk("c3_vi1", {16'd0, obs_vi[1][15:0]}, 32'h1122);
        op(1'b0, 2'd2, 1'b0, 17'h00202, 32'd0);
        chk("c3_ld", last_vo, 32'h11223344);

        // Split half store at offset 3.
        op(1'b1, 2'd1, 1'b0, 17'h00007, 32'h00008001);
        chk("c4_ai0", 32'(obs_ai[0]), 32'h0001);
        chk("c4_m0", 32'(obs_m[0]), 32'h8);
        chk("c4_ai1", 32'(obs_ai[1]), 32'h0002);
        chk("c4_m1", 32'(obs_m[1]), 32'h1);
        op(1'b0, 2'd1, 1'b1, 17'h00007, 32'd0);
        chk("c4_ld_s", last_vo, 32'hFFFF8001);
        op(1'b0, 2'd1, 1'b0, 17'h00007, 32'd0);
        chk("c4_ld_u", last_vo, 32'h00008001);

        // Split word at the top of the address space wraps to word 0.
        op(1'b1, 2'd2, 1'b0, 17'h1FFFE, 32'hCAFEBABE);
        chk("c5_ai0", 32'(obs_ai[0]), 32'h7FFF);
        chk("c5_m0", 32'(obs_m[0]), 32'hC);
        chk("c5_ai1", 32'(obs_ai[1]), 32'h0000);
        chk("c5_m1", 32'(obs_m[1]), 32'h3);
        op(1'b0, 2'd2, 1'b0, 17'h1FFFE, 32'd0);
        chk("c5_ld", last_vo, 32'hCAFEBABE);

        // Reset during the second word of a split store: first word stays written.
        @(negedge clk);
        wait_idle();
        s4 = bm[17'h00204];
        s5 = bm[17'h00205];
        #1;
        we = 1'b1; sz = 2'd2; sgn = 1'b0; ai = 17'h00202; vi = 32'hCAFEF00D; req = 1'b1;
        n_obs = 0;
        @(negedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(bus_if.we), 32'd0);
        chk("abort_bmsk", 32'(bus_if.bmsk), 32'd0);
        chk("abort_vo_vld", 32'(vo_vld), 32'd0);
        chk("abort_cnt", 32'(n_obs), 32'd1);
        bm[17'h00204] = s4;
        bm[17'h00205] = s5;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_rdy", 32'(rdy), 32'd1);
        op(1'b0, 2'd2, 1'b0, 17'h00200, 32'd0);
        chk("abort_ld_lo", last_vo, 32'hF00D0000);
        op(1'b0, 2'd2, 1'b0, 17'h00204, 32'd0);
        chk("abort_ld_hi", last_vo, 32'h00001122);

        // req held high across a load: one acceptance per idle cycle only.
        @(negedge clk);
        wait_idle();
        a0 = n_acc;
        #1;
        we = 1'b0; sz = 2'd2; sgn = 1'b0; ai = 17'h00200; vi = 32'd0; req = 1'b1;
        repeat (6) @(negedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("held_req_accepts", 32'(n_acc - a0), 32'd2);
        chk("held_req_ld", last_vo, 32'hF00D0000);

        chk("bus_queue_empty", 32'(tq.size()), 32'd0);
        chk("ld_queue_empty", 32'(lq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
